// File: rtl/toggle_burst_ctrl_if.sv
// Host <-> toggle burst controller handshake and observation bus.
interface toggle_burst_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             init_x;
  logic             abort;
  logic             busy;
  logic             done;
  logic             x_o;
  logic             y_o;
  logic             z_o;
  logic             or_o;
  logic [CNT_W-1:0] cnt_o;

  // Host side: issues bursts, watches datapath state
  modport master (
    output start, len, init_x, abort,
    input  busy, done, x_o, y_o, z_o, or_o, cnt_o
  );

  // Controller side: owns the datapath and handshake outputs
  modport slave (
    input  start, len, init_x, abort,
    output busy, done, x_o, y_o, z_o, or_o, cnt_o
  );
endinterface

// File: rtl/toggle_burst_ctrl.sv
// Bounded-burst sequencer for the toggle/shift datapath: seed load, LEN toggles,
// OR-pipe drain, one-cycle done pulse. All outputs registered.
module toggle_burst_ctrl #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  toggle_burst_ctrl_if.slave  bus
);

  localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 x;
  logic                 x_nxt;
  logic                 y;
  logic                 y_nxt;
  logic                 z;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [DW-1:0]        dcnt;
  logic [DW-1:0]        dcnt_nxt;
  logic                 busy;
  logic                 busy_nxt;
  logic                 done;
  logic                 done_nxt;
  logic [DRAIN_CYC-1:0] pipe;

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= 1'b0;
      y     <= 1'b0;
      z     <= 1'b0;
      cnt   <= '0;
      dcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pipe  <= '0;
    end else begin
      state   <= state_nxt;
      x       <= x_nxt;
      y       <= y_nxt;
      z       <= x;
      cnt     <= cnt_nxt;
      dcnt    <= dcnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      pipe[0] <= x | y;
      for (int i = 1; i < int'(DRAIN_CYC); i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Next-state and next-datapath decode; abort outranks terminal count
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    cnt_nxt   = cnt;
    dcnt_nxt  = dcnt;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            state_nxt = RUN;
            x_nxt     = bus.init_x;
            y_nxt     = 1'b0;
            cnt_nxt   = bus.len;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          x_nxt    = ~x;
          y_nxt    = x;
          cnt_nxt  = cnt - CNT_W'(1);
          dcnt_nxt = '0;
          if (cnt == CNT_W'(1)) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (dcnt == DW'(DRAIN_CYC - 1)) begin
          state_nxt = DONE;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);
    done_nxt = (state_nxt == DONE);
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.x_o   = x;
  assign bus.y_o   = y;
  assign bus.z_o   = z;
  assign bus.or_o  = pipe[DRAIN_CYC-1];
  assign bus.cnt_o = cnt;

endmodule

// File: tb/tb_toggle_burst_ctrl.sv
// Directed bench for toggle_burst_ctrl (CNT_W=8, DRAIN_CYC=2).
module tb_toggle_burst_ctrl;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   ndone;
  int   ntog;
  logic xprev;

  toggle_burst_ctrl_if #(.CNT_W(8)) bus ();

  toggle_burst_ctrl #(.CNT_W(8), .DRAIN_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_st(input string tag, input logic b, input logic d,
                           input logic xv, input logic yv, input logic [7:0] c);
    chk({tag, ".busy"}, 32'(bus.busy),  32'(b));
    chk({tag, ".done"}, 32'(bus.done),  32'(d));
    chk({tag, ".x"},    32'(bus.x_o),   32'(xv));
    chk({tag, ".y"},    32'(bus.y_o),   32'(yv));
    chk({tag, ".cnt"},  32'(bus.cnt_o), 32'(c));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.start   = 1'b1;
    bus.len     = 8'd5;
    bus.init_x  = 1'b1;
    bus.abort   = 1'b0;

    // 1: reset held for two edges with start high
    tick();
    tick();
    expect_st("rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("rst.z",  32'(bus.z_o),  32'd0);
    chk("rst.or", 32'(bus.or_o), 32'd0);
    rst = 1'b0;

    // 2: len=3, init_x=1
    bus.start = 1'b1; bus.len = 8'd3; bus.init_x = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_st("b3.k0", 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
    chk("b3.k0.z", 32'(bus.z_o), 32'd0);
    tick();
    expect_st("b3.k1", 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    chk("b3.k1.z",  32'(bus.z_o),  32'd1);
    chk("b3.k1.or", 32'(bus.or_o), 32'd0);
    tick();
    expect_st("b3.k2", 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    chk("b3.k2.z",  32'(bus.z_o),  32'd0);
    chk("b3.k2.or", 32'(bus.or_o), 32'd1);
    tick();
    expect_st("b3.k3", 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    chk("b3.k3.z", 32'(bus.z_o), 32'd1);
    tick();
    expect_st("b3.k4", 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    chk("b3.k4.z", 32'(bus.z_o), 32'd0);
    tick();
    expect_st("b3.k5", 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    chk("b3.k5.or", 32'(bus.or_o), 32'd1);
    tick();
    expect_st("b3.k6", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

    // 3: len=0 goes straight to a done pulse
    bus.start = 1'b1; bus.len = 8'd0; bus.init_x = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_st("len0.k0", 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    tick();
    expect_st("len0.k1", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

    // 4: abort two edges into a len=10 burst, then a clean len=2 burst
    bus.start = 1'b1; bus.len = 8'd10; bus.init_x = 1'b0;
    tick();
    bus.start = 1'b0;
    expect_st("ab.k0", 1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
    tick();
    tick();
    expect_st("ab.k2", 1'b1, 1'b0, 1'b0, 1'b1, 8'd8);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    expect_st("ab.k3", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    tick();
    expect_st("ab.k4", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    bus.start = 1'b1; bus.len = 8'd2; bus.init_x = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_st("ab2.k0", 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    tick();
    tick();
    expect_st("ab2.k2", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    tick();
    tick();
    expect_st("ab2.k4", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    chk("ab2.k4.or", 32'(bus.or_o), 32'd1);
    tick();

    // 5: start held high through a len=4 burst
    bus.start = 1'b1; bus.len = 8'd4; bus.init_x = 1'b0;
    tick();
    expect_st("hold.k0", 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    ndone = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    chk("hold.ndone", 32'(ndone), 32'd1);
    expect_st("hold.k7", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    tick();
    expect_st("hold.k8", 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    expect_st("hold.abort", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // 6: maximum length burst
    bus.start = 1'b1; bus.len = 8'd255; bus.init_x = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_st("max.k0", 1'b1, 1'b0, 1'b1, 1'b0, 8'd255);
    ntog = 0;
    for (int i = 0; i < 255; i++) begin
      xprev = bus.x_o;
      tick();
      if (bus.x_o !== xprev) ntog++;
    end
    chk("max.ntog", 32'(ntog), 32'd255);
    expect_st("max.k255", 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    tick();
    tick();
    expect_st("max.done", 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    chk("max.or", 32'(bus.or_o), 32'd1);
    tick();

    // Reset in the middle of a run
    bus.start = 1'b1; bus.len = 8'd100; bus.init_x = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid.busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_st("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("mid.rst.z",  32'(bus.z_o),  32'd0);
    chk("mid.rst.or", 32'(bus.or_o), 32'd0);
    tick();
    expect_st("mid.post", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
